// File: rtl/hmmm_pkg.sv
// Shared types and constants for the HMMM multicycle control sequencer.
// Optional feature macro: HMMM_SINGLE_STEP_EN adds the PAUSE state.
package hmmm_pkg;

    // Instruction register bits [9:6]; every 4-bit value names an opcode.
    typedef enum logic [3:0] {
        OP_HALT  = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_STORE = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_COPY  = 4'b0101,
        OP_NEG   = 4'b0110,
        OP_NOP   = 4'b0111,
        OP_JEQZN = 4'b1000,
        OP_JNEZN = 4'b1001,
        OP_JGTZN = 4'b1010,
        OP_JLTZN = 4'b1011,
        OP_JMP0  = 4'b1100,
        OP_JMP1  = 4'b1101,
        OP_JMP2  = 4'b1110,
        OP_JMP3  = 4'b1111
    } opcode_e;

    // Low two opcode bits of a conditional jump.
    typedef enum logic [1:0] {
        CC_EQZ = 2'b00,
        CC_NEZ = 2'b01,
        CC_GTZ = 2'b10,
        CC_LTZ = 2'b11
    } cc_e;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
`ifdef HMMM_SINGLE_STEP_EN
        ,
        S_PAUSE  = 3'd7
`endif
    } state_e;

    // PC source: sequential increment or instr[5:0] zero-extended.
    localparam logic PC_SRC_INC    = 1'b0;
    localparam logic PC_SRC_BRANCH = 1'b1;

    localparam logic WD_SEL_ALU    = 1'b0;
    localparam logic WD_SEL_MEM    = 1'b1;

    localparam logic ALU_OP_ADD    = 1'b0;
    localparam logic ALU_OP_SUB    = 1'b1;

    localparam logic ALU_SRC_ZERO  = 1'b0;
    localparam logic ALU_SRC_RD1   = 1'b1;

    // Opcodes that go through the data-memory phase instead of EXEC.
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_STORE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Conditional-jump evaluator: condition code + two's complement value -> taken.
module branch_resolve
    import hmmm_pkg::*;
(
    input  logic [1:0] cc_i,
    input  logic [3:0] br_val_i,
    output logic       taken_o
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (br_val_i == 4'd0);
    assign is_neg  = br_val_i[3];

    // Select the test named by the condition code.
    always_comb begin
        taken_o = 1'b0;
        case (cc_e'(cc_i))
            CC_EQZ:  taken_o = is_zero;
            CC_NEZ:  taken_o = !is_zero;
            CC_GTZ:  taken_o = !is_neg && !is_zero;
            CC_LTZ:  taken_o = is_neg;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hmmm_mc_sequencer.sv
// Multicycle control sequencer for the 4-bit HMMM datapath.
// Steps each instruction through FETCH / DECODE / EXEC or MEM, handshakes with
// wait-state memories, and traps to a sticky ERROR state on request timeout.
// Optional feature macro: HMMM_SINGLE_STEP_EN (adds step input and PAUSE state).
module hmmm_mc_sequencer
    import hmmm_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
`ifdef HMMM_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] funct,
    input  logic [3:0] br_val,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic       wd_sel,
    output logic       alu_op,
    output logic       alu_src,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       halted,
    output logic       err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q;
    state_e     state_d;
    state_e     done_state;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;
    opcode_e    op;
    logic       cond_taken;

    assign op = opcode_e'(funct);

    branch_resolve u_branch_resolve (
        .cc_i     (funct[1:0]),
        .br_val_i (br_val),
        .taken_o  (cond_taken)
    );

    // Where a completed instruction goes next.
    always_comb begin
`ifdef HMMM_SINGLE_STEP_EN
        // A step pulse in the completion cycle skips the PAUSE stop.
        done_state = step ? S_FETCH : S_PAUSE;
`else
        done_state = S_FETCH;
`endif
    end

    // State register and memory wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            wait_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic and all datapath controls, decoded from state, acks and funct.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_INC;
        reg_we     = 1'b0;
        wd_sel     = WD_SEL_ALU;
        alu_op     = ALU_OP_ADD;
        alu_src    = ALU_SRC_ZERO;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                // Ack wins over the timeout boundary.
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_mem_op(op)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                pc_we   = 1'b1;
                state_d = done_state;
                case (op)
                    OP_ADD: begin
                        reg_we  = 1'b1;
                        alu_op  = ALU_OP_ADD;
                        alu_src = ALU_SRC_RD1;
                    end
                    OP_SUB: begin
                        reg_we  = 1'b1;
                        alu_op  = ALU_OP_SUB;
                        alu_src = ALU_SRC_RD1;
                    end
                    OP_COPY: begin
                        reg_we  = 1'b1;
                        alu_op  = ALU_OP_ADD;
                        alu_src = ALU_SRC_ZERO;
                    end
                    OP_NEG: begin
                        reg_we  = 1'b1;
                        alu_op  = ALU_OP_SUB;
                        alu_src = ALU_SRC_ZERO;
                    end
                    OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: begin
                        pc_src = cond_taken ? PC_SRC_BRANCH : PC_SRC_INC;
                    end
                    OP_JMP0, OP_JMP1, OP_JMP2, OP_JMP3: begin
                        pc_src = PC_SRC_BRANCH;
                    end
                    default: begin
                        // NOP advances the PC only.
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_STORE);
                if (dmem_ack) begin
                    pc_we   = 1'b1;
                    state_d = done_state;
                    if (op == OP_LOAD) begin
                        reg_we = 1'b1;
                        wd_sel = WD_SEL_MEM;
                    end
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_HALT: begin
                halted = 1'b1;
                // Restart at PC+1.
                if (run) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_SRC_INC;
                    state_d = S_FETCH;
                end
            end

            S_ERROR: begin
                // Only reset leaves this state.
                err = 1'b1;
            end

`ifdef HMMM_SINGLE_STEP_EN
            S_PAUSE: begin
                halted = 1'b1;
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_hmmm_mc_sequencer.sv
// Self-checking bench for hmmm_mc_sequencer: default-timeout instance plus a
// TIMEOUT=3 instance sharing the same stimulus. With HMMM_SINGLE_STEP_EN
// defined, step is tied high so the sequencer behaves as free-running.
module tb_hmmm_mc_sequencer;

    // Positions inside the packed output vector.
    localparam int B_IMEM_REQ = 11;
    localparam int B_IR_WE    = 10;
    localparam int B_PC_WE    = 9;
    localparam int B_PC_SRC   = 8;
    localparam int B_REG_WE   = 7;
    localparam int B_WD_SEL   = 6;
    localparam int B_ALU_OP   = 5;
    localparam int B_ALU_SRC  = 4;
    localparam int B_DMEM_REQ = 3;
    localparam int B_DMEM_WE  = 2;
    localparam int B_HALTED   = 1;
    localparam int B_ERR      = 0;

    localparam logic [3:0] F_HALT  = 4'd0;
    localparam logic [3:0] F_ADD   = 4'd1;
    localparam logic [3:0] F_SUB   = 4'd2;
    localparam logic [3:0] F_STORE = 4'd3;
    localparam logic [3:0] F_LOAD  = 4'd4;
    localparam logic [3:0] F_COPY  = 4'd5;
    localparam logic [3:0] F_NEG   = 4'd6;
    localparam logic [3:0] F_JLTZN = 4'd11;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] funct;
    logic [3:0] br_val;
    logic       imem_ack;
    logic       dmem_ack;

    logic a_imem_req, a_ir_we, a_pc_we, a_pc_src, a_reg_we, a_wd_sel;
    logic a_alu_op, a_alu_src, a_dmem_req, a_dmem_we, a_halted, a_err;
    logic b_imem_req, b_ir_we, b_pc_we, b_pc_src, b_reg_we, b_wd_sel;
    logic b_alu_op, b_alu_src, b_dmem_req, b_dmem_we, b_halted, b_err;

    logic [11:0] a_vec;
    logic [11:0] b_vec;

    int  checks = 0;
    int  errors = 0;
    bit  t3_on  = 1'b1;

    assign a_vec = {a_imem_req, a_ir_we, a_pc_we, a_pc_src, a_reg_we, a_wd_sel,
                    a_alu_op, a_alu_src, a_dmem_req, a_dmem_we, a_halted, a_err};
    assign b_vec = {b_imem_req, b_ir_we, b_pc_we, b_pc_src, b_reg_we, b_wd_sel,
                    b_alu_op, b_alu_src, b_dmem_req, b_dmem_we, b_halted, b_err};

    hmmm_mc_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
`ifdef HMMM_SINGLE_STEP_EN
        .step     (1'b1),
`endif
        .funct    (funct),
        .br_val   (br_val),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (a_imem_req),
        .ir_we    (a_ir_we),
        .pc_we    (a_pc_we),
        .pc_src   (a_pc_src),
        .reg_we   (a_reg_we),
        .wd_sel   (a_wd_sel),
        .alu_op   (a_alu_op),
        .alu_src  (a_alu_src),
        .dmem_req (a_dmem_req),
        .dmem_we  (a_dmem_we),
        .halted   (a_halted),
        .err      (a_err)
    );

    hmmm_mc_sequencer #(.TIMEOUT(3)) dut_t3 (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
`ifdef HMMM_SINGLE_STEP_EN
        .step     (1'b1),
`endif
        .funct    (funct),
        .br_val   (br_val),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (b_imem_req),
        .ir_we    (b_ir_we),
        .pc_we    (b_pc_we),
        .pc_src   (b_pc_src),
        .reg_we   (b_reg_we),
        .wd_sel   (b_wd_sel),
        .alu_op   (b_alu_op),
        .alu_src  (b_alu_src),
        .dmem_req (b_dmem_req),
        .dmem_we  (b_dmem_we),
        .halted   (b_halted),
        .err      (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound on the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_both(input string tag, input logic [11:0] expv);
        check({tag, "/main"}, a_vec, expv);
        if (t3_on) check({tag, "/t3"}, b_vec, expv);
    endtask

    // Move to 1 time unit after the next rising edge; inputs are then driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: jump outcome from the signed value of the tested register.
    function automatic bit model_taken(input logic [3:0] f, input logic [3:0] v);
        int sv;
        sv = $signed(v);
        if (f[3:2] == 2'b11) return 1'b1;
        case (f[1:0])
            2'd0:    return sv == 0;
            2'd1:    return sv != 0;
            2'd2:    return sv > 0;
            default: return sv < 0;
        endcase
    endfunction

    // Reference: controls during the execute cycle of a non-memory instruction.
    function automatic logic [11:0] model_exec(input logic [3:0] f, input logic [3:0] v);
        logic [11:0] e;
        e = '0;
        e[B_PC_WE] = 1'b1;
        if (f == F_ADD || f == F_SUB || f == F_COPY || f == F_NEG) begin
            e[B_REG_WE]  = 1'b1;
            e[B_ALU_OP]  = (f == F_SUB || f == F_NEG);
            e[B_ALU_SRC] = (f == F_ADD || f == F_SUB);
        end else if (f[3]) begin
            e[B_PC_SRC] = model_taken(f, v);
        end
        return e;
    endfunction

    // One instruction: fetch with iw wait states, decode, then exec or mem
    // with dw wait states. HALT stops after decode.
    task automatic run_instr(input logic [3:0] f, input logic [3:0] bv, input int iw, input int dw);
        logic [11:0] e;
        for (int k = 0; k <= iw; k++) begin
            next_cycle();
            imem_ack = (k == iw);
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'($urandom_range(0, 1));
            funct    = (k == iw) ? f : 4'($urandom);
            br_val   = 4'($urandom);
            #1;
            e = '0;
            e[B_IMEM_REQ] = 1'b1;
            e[B_IR_WE]    = (k == iw);
            check_both("fetch", e);
        end
        next_cycle();
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        run      = 1'($urandom_range(0, 1));
        br_val   = 4'($urandom);
        #1;
        check_both("decode", 12'd0);
        if (f == F_STORE || f == F_LOAD) begin
            for (int k = 0; k <= dw; k++) begin
                next_cycle();
                dmem_ack = (k == dw);
                imem_ack = 1'($urandom_range(0, 1));
                run      = 1'($urandom_range(0, 1));
                br_val   = 4'($urandom);
                #1;
                e = '0;
                e[B_DMEM_REQ] = 1'b1;
                e[B_DMEM_WE]  = (f == F_STORE);
                if (k == dw) begin
                    e[B_PC_WE] = 1'b1;
                    if (f == F_LOAD) begin
                        e[B_REG_WE] = 1'b1;
                        e[B_WD_SEL] = 1'b1;
                    end
                end
                check_both("mem", e);
            end
        end else if (f != F_HALT) begin
            next_cycle();
            br_val   = bv;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'($urandom_range(0, 1));
            #1;
            check_both("exec", model_exec(f, bv));
        end
    endtask

    // HALT instruction, idle for gap cycles, then a run pulse.
    task automatic halt_then_run(input int gap);
        logic [11:0] e;
        run_instr(F_HALT, 4'd0, 0, 0);
        for (int k = 0; k < gap; k++) begin
            next_cycle();
            run      = 1'b0;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            e = '0;
            e[B_HALTED] = 1'b1;
            check_both("halt_wait", e);
        end
        next_cycle();
        run = 1'b1;
        #1;
        e = '0;
        e[B_HALTED] = 1'b1;
        e[B_PC_WE]  = 1'b1;
        check_both("halt_exit", e);
    endtask

    // Assert reset asynchronously mid-cycle, hold three cycles, release.
    task automatic do_reset();
        next_cycle();
        reset    = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        run      = 1'b1;
        #1;
        check_both("reset_async", 12'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'($urandom_range(0, 1));
            #1;
            check_both("reset_hold", 12'd0);
        end
        next_cycle();
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        run      = 1'b0;
        #1;
        check_both("boot", 12'd0);
    endtask

    initial begin
        logic [11:0] e;
        logic [3:0]  op;
        reset    = 1'b0;
        run      = 1'b0;
        funct    = 4'd0;
        br_val   = 4'd0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Reset, then directed instructions with zero-wait memories.
        do_reset();
        run_instr(F_ADD, 4'd0, 0, 0);
        run_instr(F_JLTZN, 4'b1000, 0, 0);
        run_instr(F_JLTZN, 4'b0000, 0, 0);
        run_instr(F_STORE, 4'd0, 0, 0);

        // HALT with restart ten cycles later.
        halt_then_run(10);

        // Random instruction stream, waits within the TIMEOUT=3 budget.
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == F_HALT) begin
                halt_then_run(int'($urandom_range(0, 3)));
            end else begin
                run_instr(op, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end

        // Long data wait: only the default-timeout instance is compared.
        t3_on = 1'b0;
        run_instr(F_LOAD, 4'd0, 1, 4);
        run_instr(F_STORE, 4'd0, 2, 2);

        // Instruction memory never answers: TIMEOUT=3 traps on FETCH cycle 5.
        t3_on = 1'b1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            imem_ack = 1'b0;
            dmem_ack = 1'($urandom_range(0, 1));
            run      = 1'($urandom_range(0, 1));
            #1;
            e = '0;
            e[B_IMEM_REQ] = 1'b1;
            check("timeout_wait/main", a_vec, e);
            e = '0;
            if (k < 5) e[B_IMEM_REQ] = 1'b1;
            else e[B_ERR] = 1'b1;
            check("timeout_trap/t3", b_vec, e);
        end
        do_reset();

        // Ack on the timeout boundary is accepted.
        run_instr(F_ADD, 4'd0, 3, 0);
        run_instr(F_LOAD, 4'd0, 3, 3);
        run_instr(F_NEG, 4'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
